// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared mode encodings and a clog2 helper for the rr_mux_arb family
package rr_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_mux_arb_grant.sv
// rr_grant: rotating priority encoder, ports i_ptr/i_req in, o_grant (one-hot)/o_idx/o_any out
module rr_grant #(
  parameter int CHANNELS = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]    i_ptr,
  input  logic [CHANNELS-1:0] i_req,
  output logic [CHANNELS-1:0] o_grant,
  output logic [SEL_W-1:0]    o_idx,
  output logic                o_any
);
  always_comb begin
    int j;
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    j = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      j = (j >= CHANNELS) ? j - CHANNELS : j;
      if (i_req[j]) begin
        o_grant = '0;
        o_grant[j] = 1'b1;
        o_idx = SEL_W'(j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered N-to-1 mux with valid/ready, fixed-select or round-robin; in_* channels in, out_* registered word out
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 16,
  parameter int SEL_W = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int SPAN = 1 << SEL_W;
  logic [SEL_W-1:0]    r_ptr;
  logic                w_load_en;
  logic [SPAN-1:0]     w_valid_ext;
  logic                w_fix_any;
  logic [CHANNELS-1:0] w_fix_grant;
  logic [CHANNELS-1:0] w_rr_grant;
  logic [SEL_W-1:0]    w_rr_idx;
  logic                w_rr_any;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_idx;
  logic                w_any;
  logic [WIDTH-1:0]    w_data;
  rr_grant #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_grant (
    .i_ptr  (r_ptr),
    .i_req  (in_valid),
    .o_grant(w_rr_grant),
    .o_idx  (w_rr_idx),
    .o_any  (w_rr_any)
  );
  assign w_load_en = !out_valid | out_ready;
  assign w_valid_ext = SPAN'(in_valid);
  assign w_fix_any = w_valid_ext[sel];
  assign w_fix_grant = w_fix_any ? (CHANNELS'(1) << sel) : '0;
  assign w_grant = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_idx = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_any = (mode == MODE_RR) ? w_rr_any : w_fix_any;
  assign in_ready = (w_load_en && !rst) ? w_grant : '0;
  always_comb begin
    w_data = '0;
    for (int i = 0; i < CHANNELS; i++) w_data = w_grant[i] ? in_data[i*WIDTH +: WIDTH] : w_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      r_ptr <= '0;
    end else if (w_load_en) begin
      out_valid <= w_any;
      if (w_any) begin
        out_data <= w_data;
        out_sel <= w_idx;
        r_ptr <= (w_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: self-checking bench for rr_mux_arb in a 16x1 fixed-select and a 5x8 round-robin configuration
module tb_rr_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic m16, ov16, or16, od16;
  logic [3:0] s16, os16;
  logic [15:0] d16, v16, rdy16;
  logic m5, ov5, or5;
  logic [2:0] s5, os5;
  logic [39:0] d5;
  logic [4:0] v5, rdy5;
  logic [7:0] od5;
  rr_mux_arb #(.WIDTH(1), .CHANNELS(16)) u16 (
    .clk(clk), .rst(rst), .mode(m16), .sel(s16), .in_data(d16), .in_valid(v16),
    .in_ready(rdy16), .out_data(od16), .out_sel(os16), .out_valid(ov16), .out_ready(or16)
  );
  rr_mux_arb #(.WIDTH(8), .CHANNELS(5)) u5 (
    .clk(clk), .rst(rst), .mode(m5), .sel(s5), .in_data(d5), .in_valid(v5),
    .in_ready(rdy5), .out_data(od5), .out_sel(os5), .out_valid(ov5), .out_ready(or5)
  );
  typedef struct packed {logic [3:0] sel; logic [7:0] data;} word_t;
  typedef struct {logic [3:0] sel; logic exp_data;} fvec_t;
  word_t q16[$];
  word_t q5[$];
  fvec_t fv[8];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic pop16(input string name);
    word_t w;
    if (q16.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    w = q16.pop_front();
    chk({name, " out_valid"}, 40'(ov16), 40'(1));
    chk({name, " out_sel"}, 40'(os16), 40'(w.sel));
    chk({name, " out_data"}, 40'(od16), 40'(w.data));
  endtask
  task automatic pop5(input string name);
    word_t w;
    if (q5.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    w = q5.pop_front();
    chk({name, " out_valid"}, 40'(ov5), 40'(1));
    chk({name, " out_sel"}, 40'(os5), 40'(w.sel));
    chk({name, " out_data"}, 40'(od5), 40'(w.data));
  endtask
  task automatic xfer5(input string name, input int ch);
    #1;
    chk({name, " in_ready"}, 40'(rdy5), 40'(5'(1) << ch));
    q5.push_back('{sel: 4'(ch), data: 8'(8'hA0 + ch)});
    step();
    pop5(name);
  endtask
  initial begin
    #50000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
  initial begin
    m16 = 1'b0; s16 = '0; d16 = 16'h3f0a; v16 = '1; or16 = 1'b1;
    m5 = 1'b1; s5 = '0; v5 = '1; or5 = 1'b1;
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'hA0 + 8'(i);
    fv = '{'{4'd0, 1'b0}, '{4'd1, 1'b1}, '{4'd2, 1'b0}, '{4'd15, 1'b0},
           '{4'd3, 1'b1}, '{4'd8, 1'b1}, '{4'd13, 1'b1}, '{4'd14, 1'b0}};
    #1 rst = 1'b1;
    #2;
    chk("reset out_valid16", 40'(ov16), 40'(0));
    chk("reset in_ready16", 40'(rdy16), 40'(0));
    chk("reset out_valid5", 40'(ov5), 40'(0));
    chk("reset in_ready5", 40'(rdy5), 40'(0));
    chk("reset out_data5", 40'(od5), 40'(0));
    @(negedge clk);
    rst = 1'b0;
    v5 = '0;
    step();
    for (int i = 0; i < 8; i++) begin
      s16 = fv[i].sel;
      #1;
      chk("fix in_ready", 40'(rdy16), 40'(16'(1) << fv[i].sel));
      q16.push_back('{sel: fv[i].sel, data: 8'(fv[i].exp_data)});
      step();
      pop16("fix");
    end
    v5 = '1;
    for (int k = 0; k < 12; k++) xfer5("rr fair", k % 5);
    v5 = 5'b10010;
    xfer5("sparse a", 4);
    xfer5("sparse b", 1);
    xfer5("sparse c", 4);
    v5 = '1;
    or5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", 40'(rdy5), 40'(0));
      step();
      chk("bp out_valid", 40'(ov5), 40'(1));
      chk("bp out_sel", 40'(os5), 40'(4));
      chk("bp out_data", 40'(od5), 40'(8'hA4));
    end
    or5 = 1'b1;
    xfer5("bp release", 0);
    m5 = 1'b0;
    s5 = 3'd5;
    #1;
    chk("oor in_ready", 40'(rdy5), 40'(0));
    step();
    chk("oor out_valid", 40'(ov5), 40'(0));
    chk("oor out_sel hold", 40'(os5), 40'(0));
    chk("oor out_data hold", 40'(od5), 40'(8'hA0));
    s5 = 3'd7;
    #1;
    chk("oor7 in_ready", 40'(rdy5), 40'(0));
    s5 = 3'd3;
    xfer5("fix5 sel3", 3);
    m5 = 1'b1;
    v5 = 5'b00010;
    xfer5("pre-reset", 1);
    v5 = '1;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid5", 40'(ov5), 40'(0));
    chk("midrst out_sel5", 40'(os5), 40'(0));
    chk("midrst out_data5", 40'(od5), 40'(0));
    chk("midrst in_ready5", 40'(rdy5), 40'(0));
    chk("midrst out_valid16", 40'(ov16), 40'(0));
    chk("midrst out_sel16", 40'(os16), 40'(0));
    rst = 1'b0;
    xfer5("post-reset", 0);
    xfer5("post-reset next", 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
